// File: rtl/complex_alu_pkg.sv
// complex_alu_pkg: opcodes, FSM state encoding, MAC controls and
// per-opcode product counts shared by the complex ALU unit.
package complex_alu_pkg;

    localparam int W_DEF = 32;

    localparam logic [3:0] OP_A    = 4'b0000;
    localparam logic [3:0] OP_B    = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_CMUL = 4'b0100;
    localparam logic [3:0] OP_RMUL = 4'b0110;
    localparam logic [3:0] OP_EQ   = 4'b1000;
    localparam logic [3:0] OP_MODA = 4'b1001;
    localparam logic [3:0] OP_MODB = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MAC_HOLD = 2'd0,
        MAC_LOAD = 2'd1,
        MAC_ADD  = 2'd2,
        MAC_SUB  = 2'd3
    } mac_op_t;

    // Number of multiplier passes an opcode needs (0 = single-cycle op).
    function automatic logic [2:0] prod_count(input logic [3:0] op);
        case (op)
            OP_CMUL: prod_count = 3'd4;
            OP_RMUL: prod_count = 3'd1;
            OP_MODA: prod_count = 3'd2;
            OP_MODB: prod_count = 3'd2;
            default: prod_count = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/complex_alu_unit_mac.sv
// signed_mac: one signed WxW product per cycle into a 2W+2 bit
// accumulator with load / add / subtract / clear control.
module signed_mac
    import complex_alu_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           clr,
    input  logic [1:0]     mac_op,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic [2*W+1:0] acc,
    output logic [2*W+1:0] acc_next
);

    logic signed [2*W-1:0] prod;
    logic [2*W+1:0]        prod_ext;

    assign prod     = $signed(x) * $signed(y);
    assign prod_ext = {{2{prod[2*W-1]}}, prod};

    // Next accumulator value; clear takes priority over the op.
    always_comb begin
        acc_next = acc;
        if (clr) begin
            acc_next = '0;
        end else begin
            case (mac_op)
                MAC_LOAD: acc_next = prod_ext;
                MAC_ADD:  acc_next = acc + prod_ext;
                MAC_SUB:  acc_next = acc - prod_ext;
                default:  acc_next = acc;
            endcase
        end
    end

    // Accumulator register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/complex_alu_unit.sv
// complex_alu_unit: start/done complex ALU, one shared multiplier.
// Define COMPLEX_ALU_SAT_EN to saturate add/sub/cmul components.
module complex_alu_unit
    import complex_alu_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [3:0]     opr,
    input  logic [2*W-1:0] a,
    input  logic [2*W-1:0] b,
    output logic [2*W-1:0] out_alux,
    output logic           done,
    output logic           busy,
    output logic           err
);

    localparam int AW = 2 * W + 2;

`ifdef COMPLEX_ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    state_t         state;
    state_t         state_d;
    logic [1:0]     cnt;
    logic [1:0]     cnt_d;
    logic [3:0]     op_q;
    logic [2*W-1:0] a_q;
    logic [2*W-1:0] b_q;
    logic [W-1:0]   hold_q;
    logic [2*W-1:0] out_q;
    logic           err_q;

    logic           accept;
    logic [2:0]     n_new;
    logic [2:0]     n_cur;
    logic           last;

    logic [2*W-1:0] simple_res;
    logic           simple_err;
    logic [2*W-1:0] prod_res;

    mac_op_t        mac_op;
    logic           mac_clr;
    logic [W-1:0]   mx;
    logic [W-1:0]   my;
    logic [AW-1:0]  acc;
    logic [AW-1:0]  acc_next;

    logic [W-1:0]   ar, ai, br, bi;
    logic [W-1:0]   qar, qai, qbr, qbi;

    assign ar  = a[2*W-1:W];
    assign ai  = a[W-1:0];
    assign br  = b[2*W-1:W];
    assign bi  = b[W-1:0];
    assign qar = a_q[2*W-1:W];
    assign qai = a_q[W-1:0];
    assign qbr = b_q[2*W-1:W];
    assign qbi = b_q[W-1:0];

    function automatic logic [AW-1:0] sx(input logic [W-1:0] v);
        return {{(AW-W){v[W-1]}}, v};
    endfunction

    // Narrow a wide signed value to W bits: wrap, or clamp when SAT.
    function automatic logic [W-1:0] fit(input logic [AW-1:0] v);
        logic hi;
        logic lo;
        hi = !v[AW-1] && (|v[AW-2:W-1]);
        lo = v[AW-1] && !(&v[AW-2:W-1]);
        if (SAT && hi) return {1'b0, {(W-1){1'b1}}};
        if (SAT && lo) return {1'b1, {(W-1){1'b0}}};
        return v[W-1:0];
    endfunction

    assign accept = (state == IDLE) && start;
    assign n_new  = prod_count(opr);
    assign n_cur  = prod_count(op_q);
    assign last   = ({1'b0, cnt} + 3'd1) >= n_cur;

    assign out_alux = out_q;
    assign err      = err_q;
    assign done     = (state == DONE);
    assign busy     = (state != IDLE);

    // Single-cycle results, formed straight from the inputs at accept.
    always_comb begin
        simple_res = '0;
        simple_err = 1'b0;
        case (opr)
            OP_A:   simple_res = a;
            OP_B:   simple_res = b;
            OP_ADD: simple_res = {fit(sx(ar) + sx(br)),
                                  fit(sx(ai) + sx(bi))};
            OP_SUB: simple_res = {fit(sx(ar) - sx(br)),
                                  fit(sx(ai) - sx(bi))};
            OP_EQ:  simple_res = {{(2*W-1){1'b0}}, (a == b)};
            OP_CMUL, OP_RMUL,
            OP_MODA, OP_MODB: simple_res = '0;
            default: simple_err = 1'b1;
        endcase
    end

    // Multiplier schedule: which operand pair and MAC op per count.
    always_comb begin
        mac_op  = MAC_HOLD;
        mac_clr = accept;
        mx      = '0;
        my      = '0;
        if (state == EXEC) begin
            case (op_q)
                OP_CMUL: begin
                    unique case (cnt)
                        2'd0: begin mx = qar; my = qbr; mac_op = MAC_LOAD; end
                        2'd1: begin mx = qai; my = qbi; mac_op = MAC_SUB;  end
                        2'd2: begin mx = qar; my = qbi; mac_op = MAC_LOAD; end
                        2'd3: begin mx = qai; my = qbr; mac_op = MAC_ADD;  end
                        default: mac_op = MAC_HOLD;
                    endcase
                end
                OP_RMUL: begin
                    mx = qar; my = qbr; mac_op = MAC_LOAD;
                end
                OP_MODA: begin
                    mx = (cnt == 2'd0) ? qar : qai;
                    my = mx;
                    mac_op = (cnt == 2'd0) ? MAC_LOAD : MAC_ADD;
                end
                OP_MODB: begin
                    mx = (cnt == 2'd0) ? qbr : qbi;
                    my = mx;
                    mac_op = (cnt == 2'd0) ? MAC_LOAD : MAC_ADD;
                end
                default: mac_op = MAC_HOLD;
            endcase
        end
    end

    // Final multi-cycle result, taken from the MAC's next value.
    always_comb begin
        prod_res = '0;
        case (op_q)
            OP_CMUL: prod_res = {hold_q, fit(acc_next)};
            OP_RMUL, OP_MODA,
            OP_MODB: prod_res = acc_next[2*W-1:0];
            default: prod_res = '0;
        endcase
    end

    signed_mac #(
        .W(W)
    ) u_mac (
        .clock    (clock),
        .reset    (reset),
        .clr      (mac_clr),
        .mac_op   (mac_op),
        .x        (mx),
        .y        (my),
        .acc      (acc),
        .acc_next (acc_next)
    );

    // FSM state and product counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Next state: single-cycle ops skip EXEC and land in DONE.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    cnt_d   = 2'd0;
                    state_d = (n_new == 3'd0) ? DONE : EXEC;
                end
            end
            EXEC: begin
                if (last) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt + 2'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand latch, real-part holding register and result/err regs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q   <= 4'd0;
            a_q    <= '0;
            b_q    <= '0;
            hold_q <= '0;
            out_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= opr;
                a_q   <= a;
                b_q   <= b;
                err_q <= simple_err;
                if (n_new == 3'd0) begin
                    out_q <= simple_res;
                end
            end
            if (state == EXEC && op_q == OP_CMUL && cnt == 2'd2) begin
                hold_q <= fit(acc);
            end
            if (state == EXEC && last) begin
                out_q <= prod_res;
            end
        end
    end

endmodule

// File: tb/tb_complex_alu_unit.sv
// tb_complex_alu_unit: scoreboard bench for complex_alu_unit with a
// directed prologue, randomized traffic and a mid-operation reset.
module tb_complex_alu_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [3:0]  opr;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] out_alux;
    logic        done;
    logic        busy;
    logic        err;

    typedef struct {
        logic [63:0] res;
        logic        err;
        int          acc_cyc;
        int          done_cyc;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          next_free = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          in_reset = 1'b1;
    logic [63:0] last_out = '0;
    logic        last_err = 1'b0;

`ifdef COMPLEX_ALU_SAT_EN
    localparam logic [31:0] ADD_OVF = 32'h7FFFFFFF;
`else
    localparam logic [31:0] ADD_OVF = 32'h80000000;
`endif

    complex_alu_unit dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .opr      (opr),
        .a        (a),
        .b        (b),
        .out_alux (out_alux),
        .done     (done),
        .busy     (busy),
        .err      (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)",
                     nm, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] fitm(input logic signed [65:0] v);
`ifdef COMPLEX_ALU_SAT_EN
        if (v > 66'sd2147483647) return 32'h7FFFFFFF;
        if (v < -66'sd2147483648) return 32'h80000000;
`endif
        return v[31:0];
    endfunction

    // Reference: plain signed arithmetic on the component values.
    function automatic void model(input logic [3:0] op,
                                  input logic [63:0] x,
                                  input logic [63:0] y,
                                  output logic [63:0] r,
                                  output logic e,
                                  output int lat);
        logic signed [65:0] xr, xi, yr, yi, p;
        xr = {{34{x[63]}}, x[63:32]};
        xi = {{34{x[31]}}, x[31:0]};
        yr = {{34{y[63]}}, y[63:32]};
        yi = {{34{y[31]}}, y[31:0]};
        r = '0;
        e = 1'b0;
        lat = 1;
        case (op)
            4'b0000: r = x;
            4'b0001: r = y;
            4'b0010: r = {fitm(xr + yr), fitm(xi + yi)};
            4'b0011: r = {fitm(xr - yr), fitm(xi - yi)};
            4'b0100: begin
                r = {fitm(xr * yr - xi * yi), fitm(xr * yi + xi * yr)};
                lat = 5;
            end
            4'b0110: begin
                p = xr * yr;
                r = p[63:0];
                lat = 2;
            end
            4'b1000: r = (x == y) ? 64'd1 : 64'd0;
            4'b1001: begin
                p = xr * xr + xi * xi;
                r = p[63:0];
                lat = 3;
            end
            4'b1010: begin
                p = yr * yr + yi * yi;
                r = p[63:0];
                lat = 3;
            end
            default: e = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] rcomp();
        case ($urandom_range(0, 5))
            0: return 32'h7FFFFFFF;
            1: return 32'h80000000;
            2: return 32'($urandom_range(0, 15));
            3: return 32'(-$urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [63:0] rnd64();
        return {rcomp(), rcomp()};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            start = 1'b0;
            opr = 4'($urandom);
            a = rnd64();
            b = rnd64();
            @(negedge clock);
        end
    endtask

    // Wait for the model's free slot (junk starts meanwhile), issue,
    // push the expected response, then scramble operands.
    task automatic issue_x(input logic [3:0] op, input logic [63:0] x,
                           input logic [63:0] y, input bit hold,
                           input logic [63:0] res, input logic e,
                           input int lat);
        exp_t t;
        while (cyc + 1 < next_free) begin
            start = hold ? 1'b1 : 1'($urandom_range(0, 1));
            opr = 4'($urandom);
            a = rnd64();
            b = rnd64();
            @(negedge clock);
        end
        start = 1'b1;
        opr = op;
        a = x;
        b = y;
        t.res = res;
        t.err = e;
        t.acc_cyc = cyc + 1;
        t.done_cyc = cyc + lat;
        q.push_back(t);
        next_free = t.done_cyc + 2;
        @(negedge clock);
        start = hold ? 1'b1 : 1'($urandom_range(0, 1));
        opr = 4'($urandom);
        a = rnd64();
        b = rnd64();
    endtask

    task automatic issue(input logic [3:0] op, input logic [63:0] x,
                         input logic [63:0] y, input bit hold);
        logic [63:0] r;
        logic        e;
        int          lat;
        model(op, x, y, r, e, lat);
        issue_x(op, x, y, hold, r, e, lat);
    endtask

    // Monitor: pops the scoreboard on done, checks busy and hold.
    always @(negedge clock) begin
        bit eb;
        if (in_reset) begin
            chk("reset_out", out_alux, 64'd0);
            chk("reset_flags", {61'd0, done, busy, err}, 64'd0);
        end else begin
            eb = q.size() > 0 && cyc >= q[0].acc_cyc &&
                 cyc <= q[0].done_cyc;
            chk("busy", 64'(busy), 64'(eb));
            if (done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", 64'(done), 64'd0);
                end else begin
                    chk("done_cycle", 64'(cyc), 64'(q[0].done_cyc));
                    chk("result", out_alux, q[0].res);
                    chk("err", 64'(err), 64'(q[0].err));
                    last_out = q[0].res;
                    last_err = q[0].err;
                    void'(q.pop_front());
                end
            end else if (q.size() > 0 && cyc > q[0].done_cyc) begin
                chk("done_missing", 64'd0, 64'd1);
                void'(q.pop_front());
            end else if (!eb) begin
                chk("hold_out", out_alux, last_out);
                chk("hold_err", 64'(err), 64'(last_err));
            end
        end
    end

    initial begin
        logic [63:0] x;
        logic [63:0] y;
        logic [3:0]  op;
        reset = 1'b0;
        start = 1'b0;
        opr = 4'd0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        in_reset = 1'b0;
        idle(2);

        issue_x(4'b0100, {32'd3, 32'd4}, {32'd1, 32'd2}, 1'b0,
                {32'hFFFFFFFB, 32'h0000000A}, 1'b0, 5);
        issue_x(4'b1001, {32'd3, 32'd4}, rnd64(), 1'b0,
                64'd25, 1'b0, 3);
        issue_x(4'b0110, {32'hFFFFFFFE, 32'd0}, {32'd5, 32'd0}, 1'b0,
                64'hFFFFFFFFFFFFFFF6, 1'b0, 2);
        issue_x(4'b0010, {32'h7FFFFFFF, 32'd0}, {32'd1, 32'd0}, 1'b0,
                {ADD_OVF, 32'd0}, 1'b0, 1);
        issue_x(4'b0101, rnd64(), rnd64(), 1'b0, 64'd0, 1'b1, 1);
        idle(2);
        issue_x(4'b0000, 64'h0123456789ABCDEF, rnd64(), 1'b0,
                64'h0123456789ABCDEF, 1'b0, 1);
        issue_x(4'b1000, 64'h1234, 64'h1234, 1'b0, 64'd1, 1'b0, 1);
        idle(4);
        issue_x(4'b1010, rnd64(), {32'hFFFFFFFD, 32'd4}, 1'b1,
                64'd25, 1'b0, 3);
        issue_x(4'b0011, {32'd10, 32'd1}, {32'd3, 32'd5}, 1'b1,
                {32'd7, 32'hFFFFFFFC}, 1'b0, 1);
        issue_x(4'b0001, rnd64(), 64'hCAFEF00D5EED1234, 1'b1,
                64'hCAFEF00D5EED1234, 1'b0, 1);
        idle(2);

        for (int i = 0; i < 250; i++) begin
            op = 4'($urandom);
            x = rnd64();
            y = ($urandom_range(0, 3) == 0) ? x : rnd64();
            issue(op, x, y, ($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(8);

        issue_x(4'b1000, 64'h55, 64'h55, 1'b0, 64'd1, 1'b0, 1);
        idle(2);
        issue(4'b0100, rnd64(), rnd64(), 1'b1);
        @(negedge clock);
        #1;
        reset = 1'b0;
        in_reset = 1'b1;
        start = 1'b0;
        q.delete();
        next_free = 0;
        repeat (3) @(negedge clock);
        last_out = '0;
        last_err = 1'b0;
        reset = 1'b1;
        in_reset = 1'b0;
        idle(6);
        issue(4'b0100, rnd64(), rnd64(), 1'b0);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clock);
        if (q.size() > 0) chk("drain", 64'(q.size()), 64'd0);
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/complex_alu_unit.md
Name: complex_alu_unit

Overview:
- Execution end of the start/opr/done/out_alux handshake: accepts one opcode plus two complex operands per start, computes the result, and returns it with a one-cycle done pulse.
- Sits between the operand registers and the operation controller, which issues start/opr and waits on done or its own timeout.
- Operands are 64-bit complex words {real[63:32], imag[31:0]}, each component signed two's complement.
- Multiplying ops share one signed multiplier, sequenced at one product per cycle.

Parameters:
- W, 32: component width; operand and result words are 2*W bits.

Ports:
- clock  in  1  master clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- opr  in  4  opcode, latched with start.
- a  in  2W  operand A, latched with start.
- b  in  2W  operand B, latched with start.
- out_alux  out  2W  result; held stable from done until the next accepted start.
- done  out  1  one-cycle pulse when out_alux is valid.
- busy  out  1  high from the cycle after acceptance through the done cycle.
- err  out  1  high with done for an unsupported opcode; held until the next accept.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; out_alux=0, done=0, busy=0, err=0; accumulator and counter cleared.
- Reset mid-operation: the operation is aborted and no done pulse occurs.
- Accept: on a rising edge k with state IDLE and start=1, latch opr, a and b. A start seen while busy is ignored and does not queue.
- States: IDLE -> EXEC -> DONE -> IDLE. EXEC has a product counter of 0..3. DONE lasts one cycle and asserts done.
- Opcodes, with the cycle in which done is high:
  - 0000: A. Done at k+1.
  - 0001: B. Done at k+1.
  - 0010: A+B per component. Done at k+1.
  - 0011: A-B per component. Done at k+1.
  - 0100: complex product {ar*br-ai*bi, ar*bi+ai*br}. 4 products. Done at k+5.
  - 0110: real product ar*br, full 2W-bit signed result. 1 product. Done at k+2.
  - 1000: A==B over all 2W bits; out_alux=1 if equal, else 0. Done at k+1.
  - 1001: |A|^2 = ar^2+ai^2 as an unsigned 2W-bit result. 2 products. Done at k+3.
  - 1010: |B|^2, same as 1001 using B. Done at k+3.
  - Any other opcode: out_alux=0, err=1. Done at k+1.
- Arithmetic and width rules:
  - Add, sub and complex-product components are truncated (wrapped) to W bits.
  - Products are formed at full 2W width internally before truncation.
- Boundaries:
  - start held high continuously: a new accept occurs in the IDLE cycle following DONE, so the minimum issue interval is latency+1.
  - Operand changes after the accept edge have no effect on the result.

Optional Feature:
- COMPLEX_ALU_SAT_EN defined: 0010, 0011 and the 0100 components saturate to the signed W-bit range (0x7FFFFFFF / 0x80000000 for W=32).
- Not defined: those ops wrap.
- Latency is identical in both builds.

Decomposition:
- Package complex_alu_pkg holds:
  - opcode localparams (OP_A, OP_B, OP_ADD, OP_SUB, OP_CMUL, OP_RMUL, OP_EQ, OP_MODA, OP_MODB);
  - the state encoding (IDLE, EXEC, DONE);
  - the per-opcode product count;
  - the default W.
- One sub-module, signed_mac: registered signed WxW multiply with accumulate/subtract/clear control, one product per cycle.

Test Plan:
- Complex product: opr=0100, a={3,4}, b={1,2}, start at k -> done at k+5, out_alux={32'hFFFFFFFB,32'h0000000A}, busy high k+1..k+5.
- Modulus: opr=1001, a={3,4} -> done at k+3, out_alux=64'd25. Same with opr=0110, a={-2,0}, b={5,0} -> done at k+2, out_alux=-10 (64-bit).
- Add overflow: opr=0010, a={32'h7FFFFFFF,0}, b={1,0} -> without SAT real=32'h80000000; with COMPLEX_ALU_SAT_EN real=32'h7FFFFFFF. Done at k+1 in both builds.
- Invalid opcode: opr=0101 -> done at k+1, err=1, out_alux=0. A following valid op clears err at accept.
- Busy/abort: second start during complex product -> ignored, exactly one done. reset=0 at k+2 -> done never pulses; out_alux=0, busy=0, state IDLE.
- Equality and hold: opr=1000, a=b=64'h1234 -> out_alux=1. Change a/b after accept -> result unchanged and held until the next start.
